alu_exec_stage: RTL

- Registered ALU execution stage that consumes the 3-bit ALU control code produced by the ALU decoder, plus two operands.
- Computes the result, zero flag and illegal-op flag, and presents them downstream through a valid/ready handshake.
- Contains a 2-entry output buffer (main register + skid register), so downstream back-pressure never drops or duplicates a result.
- Sits between decode/operand-select and writeback/branch resolution.

---
 rtl/alu_exec_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Registered ALU execution stage with a main/skid output buffer and valid/ready handshakes.
// Results leave in acceptance order; o_Ready depends only on registered state.
module alu_exec_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [2:0]            i_AluControl,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [DATA_WIDTH-1:0] o_Result,
    output logic                  o_Zero,
    output logic                  o_Illegal
);

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_illegal;
    logic                  alu_slt;

    logic                  main_valid_q;
    logic [DATA_WIDTH-1:0] main_result_q;
    logic                  main_zero_q;
    logic                  main_illegal_q;

    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_result_q;
    logic                  skid_zero_q;
    logic                  skid_illegal_q;

    logic                  accept;
    logic                  transfer;

    assign alu_slt = ($signed(i_SrcA) < $signed(i_SrcB));

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (i_AluControl)
            3'b000:  alu_result = i_SrcA + i_SrcB;
            3'b001:  alu_result = i_SrcA - i_SrcB;
            3'b010:  alu_result = i_SrcA & i_SrcB;
            3'b011:  alu_result = i_SrcA | i_SrcB;
            3'b101:  alu_result = {{(DATA_WIDTH-1){1'b0}}, alu_slt};
            default: alu_illegal = 1'b1;
        endcase
    end

    // Illegal codes leave the result at zero, so the zero flag follows naturally.
    assign alu_zero = (alu_result == '0);

    assign o_Ready   = ~skid_valid_q;
    assign o_Valid   = main_valid_q;
    assign o_Result  = main_result_q;
    assign o_Zero    = main_zero_q;
    assign o_Illegal = main_illegal_q;

    assign accept   = i_Valid & ~skid_valid_q;
    assign transfer = main_valid_q & i_Ready;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            main_valid_q   <= 1'b0;
            main_result_q  <= '0;
            main_zero_q    <= 1'b0;
            main_illegal_q <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_result_q  <= '0;
            skid_zero_q    <= 1'b0;
            skid_illegal_q <= 1'b0;
        end else if (skid_valid_q) begin
            // FULL: only a downstream transfer can make progress.
            if (transfer) begin
                main_result_q  <= skid_result_q;
                main_zero_q    <= skid_zero_q;
                main_illegal_q <= skid_illegal_q;
                skid_valid_q   <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || transfer) begin
                main_valid_q   <= 1'b1;
                main_result_q  <= alu_result;
                main_zero_q    <= alu_zero;
                main_illegal_q <= alu_illegal;
            end else begin
                skid_valid_q   <= 1'b1;
                skid_result_q  <= alu_result;
                skid_zero_q    <= alu_zero;
                skid_illegal_q <= alu_illegal;
            end
        end else if (transfer) begin
            main_valid_q <= 1'b0;
        end
    end

endmodule
